pipe_stall_ctrl: RTL

Parametrised pipeline stall/flush controller for the in-order CPU core. It generalises the fixed 6-bit stall controller in three ways:
- N stages and N stall-request sources, each source with a configurable stall depth.
- Exception flush with deferral while a blocking (memory-side) stall is in flight.
- A stall watchdog and per-source stall-cycle performance counters.

It sits beside the pipeline registers and drives their stall/flush inputs and the PC redirect.

---
 rtl/pipe_stall_ctrl_pkg.sv | 24 ++
 rtl/stall_perf_cnt.sv | 55 +++++
 rtl/pipe_stall_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Stage indices follow the legacy 6-stage layout (PC at bit 0, WB at the top).
package pipe_stall_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum int {
        STG_PC  = 0,
        STG_IF  = 1,
        STG_ID  = 2,
        STG_EX  = 3,
        STG_MEM = 4,
        STG_WB  = 5
    } stage_idx_e;

    typedef enum logic [0:0] {
        FS_IDLE = 1'b0,
        FS_PEND = 1'b1
    } flush_state_e;

endpackage

// File: rtl/stall_perf_cnt.sv
// Per-source saturating stall-cycle counters with a global clear and read mux.
// Only the winning source's counter advances on a counted cycle.
module stall_perf_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_en,
    input  logic [SEL_W-1:0] win_idx,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] cnt_out
);

    logic [CNT_W-1:0] cnt_r [N_REQ];
    logic [CNT_W-1:0] rd_s;

    // Counter bank: clear beats increment, counters stick at all-ones
    always_ff @(posedge clk) begin
        if (rst == RstEnable || clr) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (inc_en && (win_idx == SEL_W'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Read mux; an out-of-range select matches nothing and reads zero
    always_comb begin
        rd_s = '0;
        if (rst == RstEnable) begin
            rd_s = '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (sel == SEL_W'(i)) begin
                    rd_s = cnt_r[i];
                end else begin
                    rd_s = rd_s;
                end
            end
        end
    end

    assign cnt_out = rd_s;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prefix stall mask, deferred exception flush,
// stall watchdog and per-source stall-cycle counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int                         N_STAGES    = int'(STG_WB) + 1,
    parameter int                         N_REQ       = 4,
    parameter int                         DEPTH_W     = 4,
    parameter logic [N_REQ*DEPTH_W-1:0]   REQ_DEPTH   = {4'(STG_IF), 4'(STG_ID), 4'(STG_IF), 4'(STG_MEM)},
    parameter int                         BLOCK_DEPTH = 4,
    parameter int                         TIMEOUT     = 1024,
    parameter int                         CNT_W       = 32,
    parameter int                         SEL_W       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    stall_req,
    input  logic                flush_req,
    input  logic [31:0]         exc_pc,
    output logic [N_STAGES-1:0] stall,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                stall_timeout,
    input  logic [SEL_W-1:0]    perf_sel,
    input  logic                perf_clr,
    output logic [CNT_W-1:0]    perf_cnt
);

    localparam logic [DEPTH_W-1:0] BLOCK_D = DEPTH_W'(BLOCK_DEPTH);
    localparam int                 TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]    TO_MAX  = TO_W'(TIMEOUT);

    logic                any_req_s;
    logic                blocked_s;
    logic [DEPTH_W-1:0]  depth_s;
    logic [DEPTH_W-1:0]  max_depth_s;
    logic [SEL_W-1:0]    win_s;
    flush_state_e        state_r;
    flush_state_e        state_nxt_s;
    logic [31:0]         pend_pc_r;
    logic                latch_pc_s;
    logic                flush_s;
    logic [31:0]         new_pc_s;
    logic [N_STAGES-1:0] stall_s;
    logic                stalling_s;
    logic [TO_W-1:0]     stall_cnt_r;
    logic                timeout_r;

    // Resolve deepest request; strict compare keeps the lowest index on ties
    always_comb begin
        any_req_s   = 1'b0;
        blocked_s   = 1'b0;
        depth_s     = '0;
        max_depth_s = '0;
        win_s       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            depth_s = REQ_DEPTH[i*DEPTH_W +: DEPTH_W];
            if (stall_req[i]) begin
                blocked_s = blocked_s | (depth_s >= BLOCK_D);
                if (!any_req_s || (depth_s > max_depth_s)) begin
                    any_req_s   = 1'b1;
                    max_depth_s = depth_s;
                    win_s       = SEL_W'(i);
                end else begin
                    max_depth_s = max_depth_s;
                end
            end else begin
                blocked_s = blocked_s;
            end
        end
    end

    // Flush FSM: flush at once unless a memory-side stall must drain first
    always_comb begin
        state_nxt_s = state_r;
        flush_s     = 1'b0;
        new_pc_s    = ZeroWord;
        latch_pc_s  = 1'b0;
        if (rst == RstEnable) begin
            state_nxt_s = FS_IDLE;
        end else begin
            case (state_r)
                FS_IDLE: begin
                    if (flush_req) begin
                        if (!blocked_s) begin
                            flush_s  = 1'b1;
                            new_pc_s = exc_pc;
                        end else begin
                            state_nxt_s = FS_PEND;
                            latch_pc_s  = 1'b1;
                        end
                    end else begin
                        state_nxt_s = FS_IDLE;
                    end
                end
                FS_PEND: begin
                    if (!blocked_s) begin
                        flush_s     = 1'b1;
                        new_pc_s    = pend_pc_r;
                        state_nxt_s = FS_IDLE;
                    end else begin
                        state_nxt_s = FS_PEND;
                    end
                end
                default: state_nxt_s = FS_IDLE;
            endcase
        end
    end

    // FSM state and pending redirect target
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r   <= FS_IDLE;
            pend_pc_r <= ZeroWord;
        end else begin
            state_r <= state_nxt_s;
            if (latch_pc_s) begin
                pend_pc_r <= exc_pc;
            end
        end
    end

    // Prefix stall mask up to the deepest requested stage; a flush overrides
    always_comb begin
        stall_s = '0;
        if ((rst == RstEnable) || flush_s || !any_req_s) begin
            stall_s = '0;
        end else begin
            for (int j = 0; j < N_STAGES; j++) begin
                stall_s[j] = (DEPTH_W'(j) <= max_depth_s) ? Stop : NoStop;
            end
        end
    end

    assign stalling_s = |stall_s;

    // Watchdog: count consecutive stalled cycles, latch a sticky timeout
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt_r <= '0;
            timeout_r   <= 1'b0;
        end else if (!stalling_s || flush_s) begin
            stall_cnt_r <= '0;
        end else begin
            if (stall_cnt_r != TO_MAX) begin
                stall_cnt_r <= stall_cnt_r + TO_W'(1);
            end
            if (stall_cnt_r >= TO_LAST) begin
                timeout_r <= 1'b1;
            end
        end
    end

    stall_perf_cnt #(
        .N_REQ (N_REQ),
        .CNT_W (CNT_W),
        .SEL_W (SEL_W)
    ) u_perf (
        .clk     (clk),
        .rst     (rst),
        .clr     (perf_clr),
        .inc_en  (stalling_s & ~flush_s),
        .win_idx (win_s),
        .sel     (perf_sel),
        .cnt_out (perf_cnt)
    );

    assign stall         = stall_s;
    assign flush         = flush_s;
    assign new_pc        = new_pc_s;
    assign stall_timeout = timeout_r;

endmodule
